ld_st_rs_scheduler: RTL and testbench
=====================================

# ld_st_rs_scheduler

Control-side partner of the load/store reservation station. Picks the free slot for each dispatched load/store, tracks relative age of occupied slots in an age matrix, and selects the oldest ready entry for issue to the memory unit under a valid/ready handshake. Drives the station's write-enable, write address, read address and complete strobe; consumes its valid and ready bit vectors.

## Interface

- QUEUE_DEPTH, 4, number of station slots; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dispatch_valid  in  1  rename/dispatch presents a load/store packet this cycle
- dispatch_ready  out  1  at least one free slot; packet accepted when both high
- rs_queue_valid_bits  in  QUEUE_DEPTH  per-slot valid from the station (registered state)
- rs_ready_bits  in  QUEUE_DEPTH  per-slot operand-ready, mispredict-squashed, from the station
- rs_station_wen  out  1  write dispatch packet into slot rs_station_waddr
- rs_station_waddr  out  $clog2(QUEUE_DEPTH)  target slot for dispatch write
- rs_station_raddr  out  $clog2(QUEUE_DEPTH)  slot presented to memory unit
- rs_station_complete  out  1  issued entry retires from the station this cycle
- issue_valid  out  1  rs_station_raddr holds an issuable entry
- mem_unit_ready  in  1  memory unit accepts an entry this cycle

## Operation

- Allocation: waddr = lowest-index slot with rs_queue_valid_bits[i]=0; '0 when none. dispatch_ready = |~rs_queue_valid_bits. rs_station_wen = dispatch_valid & dispatch_ready.
- A slot freed by complete in cycle t is still valid in t, so it is never reallocated in t; first reuse is t+1.
- Age matrix older[i][j] (QUEUE_DEPTH×QUEUE_DEPTH registers, diagonal ignored). On wen to slot w: row w cleared, column w set for every j≠w (w is youngest). Entries for invalid slots are ignored, never explicitly cleared.
- Selection: candidate i = rs_ready_bits[i] & rs_queue_valid_bits[i] & no other candidate j with older[j][i]. Exactly one candidate wins.
- FSM, two states:
  - IDLE: issue_valid = |candidates; raddr = winner. If issue_valid & mem_unit_ready → complete=1, stay IDLE. If issue_valid & ~mem_unit_ready → latch raddr into held_idx, go HOLD.
  - HOLD: raddr = held_idx; issue_valid = rs_queue_valid_bits[held_idx] & rs_ready_bits[held_idx]. If mem_unit_ready & issue_valid → complete=1, go IDLE. If rs_queue_valid_bits[held_idx]=0 (squashed) or rs_ready_bits[held_idx]=0 (squash in progress) → issue_valid=0, go IDLE without complete. Else stay HOLD.
- HOLD never switches to an older entry that becomes ready later; selection is stable once presented.
- rs_station_complete = issue_valid & mem_unit_ready; at most one per cycle.
- Dispatch and issue are independent and may both occur in one cycle.

## Timing

- Reset: state IDLE, held_idx 0, age matrix 0. Outputs after reset (station empty): dispatch_ready 1, wen 0, waddr 0, raddr 0, issue_valid 0, complete 0.
- Allocation and issue decisions combinational from current inputs; only FSM state, held_idx and age matrix are registered.
- Entry written in cycle t is visible in rs_queue_valid_bits at t+1; earliest issue t+1 when operands ready.
- Back-to-back issue with mem_unit_ready held high: one complete per cycle.
- rst mid-HOLD: returns to IDLE next edge, no complete asserted in the reset cycle.

## Test plan

- Reset then dispatch 4 packets cycles 1–4 → waddr 0,1,2,3; dispatch_ready 0 at cycle 5 with valid bits 4'b1111.
- Slots 0..3 written in order 2,0,3,1; all ready, mem_unit_ready=1 → complete order raddr 2,0,3,1, one per cycle.
- Slot 1 oldest, ready bits 4'b1010, mem_unit_ready=0 for 3 cycles → HOLD, raddr 1 stable, issue_valid 1, complete 0; release → complete with raddr 1.
- In HOLD on slot 2, valid bit 2 drops (mispredict) → issue_valid 0 next cycle, IDLE, no complete; next oldest ready slot selected.
- Full queue, complete slot 3 at t with dispatch_valid=1 → wen 0 at t, wen 1 waddr 3 at t+1.
- Simultaneous dispatch into slot 0 and issue of slot 2 in same cycle → wen 1 waddr 0 and complete 1 raddr 2; new slot 0 youngest in age matrix.

Source files
------------

// File: rtl/ld_st_rs_scheduler.sv
// rtl/ld_st_rs_scheduler.sv - load/store reservation station slot allocator, age tracker and issue scheduler
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dispatch_valid/ready     dispatch handshake; ready while any slot is free
//   rs_queue_valid_bits      per-slot occupancy from the station
//   rs_ready_bits            per-slot operand-ready (squash-masked) from the station
//   rs_station_wen/waddr     write strobe and slot for the dispatched packet
//   rs_station_raddr         slot presented to the memory unit
//   rs_station_complete      presented entry accepted and retires this cycle
//   issue_valid              rs_station_raddr holds an issuable entry
//   mem_unit_ready           memory unit accepts an entry this cycle
module ld_st_rs_scheduler #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  input  logic [QUEUE_DEPTH-1:0]         rs_queue_valid_bits,
  input  logic [QUEUE_DEPTH-1:0]         rs_ready_bits,
  output logic                           rs_station_wen,
  output logic [$clog2(QUEUE_DEPTH)-1:0] rs_station_waddr,
  output logic [$clog2(QUEUE_DEPTH)-1:0] rs_station_raddr,
  output logic                           rs_station_complete,
  output logic                           issue_valid,
  input  logic                           mem_unit_ready
);

  localparam int IDX_W = $clog2(QUEUE_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                                  state_q, state_d;
  logic [IDX_W-1:0]                        held_q;
  // older_q[i][j] = slot i was dispatched before slot j
  logic [QUEUE_DEPTH-1:0][QUEUE_DEPTH-1:0] older_q;

  logic [IDX_W-1:0]       alloc_idx;
  logic [QUEUE_DEPTH-1:0] cand;
  logic [QUEUE_DEPTH-1:0] win;
  logic [IDX_W-1:0]       sel_idx;
  logic                   any_cand;
  logic                   latch_held;

  // Lowest-index free slot.
  always_comb begin
    alloc_idx = '0;
    for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
      if (!rs_queue_valid_bits[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign dispatch_ready   = |(~rs_queue_valid_bits);
  assign rs_station_wen   = dispatch_valid & dispatch_ready;
  assign rs_station_waddr = alloc_idx;

  assign cand     = rs_ready_bits & rs_queue_valid_bits;
  assign any_cand = |cand;

  // A candidate wins when no other candidate is older than it. The matrix
  // gives a total order over valid slots, so one winner exists; the index
  // priority below only matters if the matrix is still all-zero after reset.
  always_comb begin
    win = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < QUEUE_DEPTH; j++) begin
        if (j != i && cand[j] && older_q[j][i]) blocked = 1'b1;
      end
      win[i] = cand[i] & ~blocked;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
      if (win[i]) sel_idx = IDX_W'(i);
    end
  end

  // Issue FSM: IDLE presents the current winner; HOLD pins the presented
  // slot until it is taken or squashed, even if an older one becomes ready.
  always_comb begin
    state_d          = state_q;
    issue_valid      = 1'b0;
    rs_station_raddr = sel_idx;
    latch_held       = 1'b0;
    case (state_q)
      IDLE: begin
        issue_valid = any_cand;
        if (any_cand && !mem_unit_ready) begin
          state_d    = HOLD;
          latch_held = 1'b1;
        end
      end
      HOLD: begin
        rs_station_raddr = held_q;
        issue_valid      = rs_queue_valid_bits[held_q] & rs_ready_bits[held_q];
        if (!issue_valid || mem_unit_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Nothing issues while reset is asserted, whatever state we are leaving.
    if (rst) issue_valid = 1'b0;
  end

  assign rs_station_complete = issue_valid & mem_unit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_held) held_q <= sel_idx;
    end
  end

  // New entry becomes the youngest: it is older than nobody, everyone else
  // is older than it. Rows/columns of free slots are left stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      older_q <= '0;
    end else if (rs_station_wen) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        for (int j = 0; j < QUEUE_DEPTH; j++) begin
          if (IDX_W'(i) == alloc_idx) begin
            older_q[i][j] <= 1'b0;
          end else if (IDX_W'(j) == alloc_idx) begin
            older_q[i][j] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ld_st_rs_scheduler.sv
// tb/tb_ld_st_rs_scheduler.sv - self-checking bench for ld_st_rs_scheduler
module tb_ld_st_rs_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       dispatch_valid;
  logic       dispatch_ready;
  logic [3:0] rs_queue_valid_bits;
  logic [3:0] rs_ready_bits;
  logic       rs_station_wen;
  logic [1:0] rs_station_waddr;
  logic [1:0] rs_station_raddr;
  logic       rs_station_complete;
  logic       issue_valid;
  logic       mem_unit_ready;

  ld_st_rs_scheduler #(.QUEUE_DEPTH(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dispatch_valid      (dispatch_valid),
    .dispatch_ready      (dispatch_ready),
    .rs_queue_valid_bits (rs_queue_valid_bits),
    .rs_ready_bits       (rs_ready_bits),
    .rs_station_wen      (rs_station_wen),
    .rs_station_waddr    (rs_station_waddr),
    .rs_station_raddr    (rs_station_raddr),
    .rs_station_complete (rs_station_complete),
    .issue_valid         (issue_valid),
    .mem_unit_ready      (mem_unit_ready)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Station + scheduler reference: occupancy bits, dispatch-order list of
  // occupied slots, and whether a presented entry is being held.
  logic [3:0] st_valid;
  int         age_q[$];
  bit         m_hold;
  int         m_held;

  logic       s_dr, s_wen, s_iv, s_comp;
  logic [1:0] s_wa, s_ra;

  typedef struct {
    logic       dv;
    logic [3:0] v;
    logic [3:0] r;
    logic       m;
    logic       dr;
    logic       wen;
    logic [1:0] wa;
    logic       iv;
    logic [1:0] ra;
    logic       c;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, name, act, exp);
    end
  endtask

  // Called just after a negedge; applies one cycle of inputs, checks all
  // outputs against the reference, then advances the reference at posedge.
  task automatic cycle(input bit dv, input bit mur, input logic [3:0] rdy, input logic [3:0] sq);
    bit         e_dr, e_wen, e_iv, e_comp;
    int         e_wa, e_ra;
    logic [3:0] pre_valid;
    int         nq[$];
    dispatch_valid      = dv;
    mem_unit_ready      = mur;
    rs_ready_bits       = rdy;
    rs_queue_valid_bits = st_valid;
    e_dr = (st_valid != 4'hF);
    e_wa = 0;
    for (int i = 3; i >= 0; i--) if (!st_valid[i]) e_wa = i;
    e_wen = dv && e_dr;
    e_iv  = 1'b0;
    e_ra  = 0;
    if (m_hold) begin
      e_ra = m_held;
      e_iv = st_valid[m_held] && rdy[m_held];
    end else begin
      for (int k = 0; k < age_q.size(); k++) begin
        if (!e_iv && st_valid[age_q[k]] && rdy[age_q[k]]) begin
          e_iv = 1'b1;
          e_ra = age_q[k];
        end
      end
    end
    e_comp = e_iv && mur;
    #1;
    s_dr = dispatch_ready; s_wen = rs_station_wen; s_wa = rs_station_waddr;
    s_iv = issue_valid;    s_ra = rs_station_raddr; s_comp = rs_station_complete;
    check("dispatch_ready", s_dr, e_dr);
    check("wen", s_wen, e_wen);
    check("waddr", s_wa, e_wa);
    check("issue_valid", s_iv, e_iv);
    if (e_iv) check("raddr", s_ra, e_ra);
    check("complete", s_comp, e_comp);
    @(posedge clk);
    pre_valid = st_valid;
    if (m_hold) begin
      if (!e_iv || mur) m_hold = 1'b0;
    end else if (e_iv && !mur) begin
      m_hold = 1'b1;
      m_held = e_ra;
    end
    if (e_comp) st_valid[e_ra] = 1'b0;
    if (e_wen) begin
      st_valid[e_wa] = 1'b1;
      age_q.push_back(e_wa);
    end
    st_valid = st_valid & ~(sq & pre_valid);
    for (int k = 0; k < age_q.size(); k++) if (st_valid[age_q[k]]) nq.push_back(age_q[k]);
    age_q = nq;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    dispatch_valid      = 1'b0;
    mem_unit_ready      = 1'b1;
    rs_ready_bits       = 4'hF;
    rs_queue_valid_bits = st_valid;
    #1;
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_complete", rs_station_complete, 1'b0);
    @(posedge clk);
    rst      = 1'b0;
    st_valid = '0;
    age_q.delete();
    m_hold   = 1'b0;
    m_held   = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; dispatch_valid = 1'b0; mem_unit_ready = 1'b0;
    rs_ready_bits = '0; rs_queue_valid_bits = '0;
    st_valid = '0; m_hold = 1'b0; m_held = 0;
    @(negedge clk);
    do_reset();

    phase = "reset_outputs";
    cycle(0, 0, 4'h0, 4'h0);
    check("r_dispatch_ready", s_dr, 1'b1);
    check("r_wen", s_wen, 1'b0);
    check("r_waddr", s_wa, 2'd0);
    check("r_raddr", s_ra, 2'd0);
    check("r_issue_valid", s_iv, 1'b0);
    check("r_complete", s_comp, 1'b0);

    // Combinational allocation/selection vectors; at most one candidate, so
    // age order is irrelevant, and never a stall so the FSM stays idle.
    phase = "table";
    tbl[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0};
    tbl[2] = '{1'b0, 4'b0011, 4'b0010, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 2'd1, 1'b1};
    tbl[3] = '{1'b1, 4'b0111, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 2'd2, 1'b1};
    tbl[4] = '{1'b1, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1};
    tbl[5] = '{1'b1, 4'b1011, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 2'd0, 1'b1};
    tbl[6] = '{1'b0, 4'b1101, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0};
    for (int t = 0; t < 8; t++) begin
      dispatch_valid      = tbl[t].dv;
      rs_queue_valid_bits = tbl[t].v;
      rs_ready_bits       = tbl[t].r;
      mem_unit_ready      = tbl[t].m;
      #1;
      check("t_dispatch_ready", dispatch_ready, tbl[t].dr);
      check("t_wen", rs_station_wen, tbl[t].wen);
      check("t_waddr", rs_station_waddr, tbl[t].wa);
      check("t_issue_valid", issue_valid, tbl[t].iv);
      check("t_raddr", rs_station_raddr, tbl[t].ra);
      check("t_complete", rs_station_complete, tbl[t].c);
      @(negedge clk);
    end
    st_valid = '0;
    do_reset();

    phase = "fill";
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 4'h0, 4'h0);
      check("fill_waddr", s_wa, i);
    end
    cycle(1, 0, 4'h0, 4'h0);
    check("full_dispatch_ready", s_dr, 1'b0);
    check("full_wen", s_wen, 1'b0);

    phase = "stall";
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 4'b1010, 4'h0);
      check("hold_raddr", s_ra, 2'd1);
      check("hold_issue_valid", s_iv, 1'b1);
      check("hold_complete", s_comp, 1'b0);
    end
    cycle(0, 1, 4'b1010, 4'h0);
    check("release_raddr", s_ra, 2'd1);
    check("release_complete", s_comp, 1'b1);

    phase = "full_reuse";
    cycle(1, 0, 4'h0, 4'h0);
    check("refill_waddr", s_wa, 2'd1);
    cycle(1, 1, 4'b1000, 4'h0);
    check("reuse_t_wen", s_wen, 1'b0);
    check("reuse_t_raddr", s_ra, 2'd3);
    check("reuse_t_complete", s_comp, 1'b1);
    cycle(1, 0, 4'h0, 4'h0);
    check("reuse_t1_wen", s_wen, 1'b1);
    check("reuse_t1_waddr", s_wa, 2'd3);

    phase = "squash";
    cycle(0, 0, 4'b0100, 4'h0);
    check("sq_hold_raddr", s_ra, 2'd2);
    cycle(0, 0, 4'b0100, 4'b0100);
    check("sq_t_issue_valid", s_iv, 1'b1);
    cycle(0, 0, 4'b1011, 4'h0);
    check("sq_t1_issue_valid", s_iv, 1'b0);
    check("sq_t1_complete", s_comp, 1'b0);
    cycle(0, 1, 4'b1011, 4'h0);
    check("sq_next_raddr", s_ra, 2'd0);
    check("sq_next_complete", s_comp, 1'b1);

    phase = "dual";
    cycle(1, 0, 4'h0, 4'h0);
    cycle(1, 0, 4'h0, 4'h0);
    cycle(0, 0, 4'h0, 4'b0001);
    cycle(1, 1, 4'b0100, 4'h0);
    check("dual_wen", s_wen, 1'b1);
    check("dual_waddr", s_wa, 2'd0);
    check("dual_complete", s_comp, 1'b1);
    check("dual_raddr", s_ra, 2'd2);
    cycle(0, 1, 4'hF, 4'h0); check("dual_drain0", s_ra, 2'd1);
    cycle(0, 1, 4'hF, 4'h0); check("dual_drain1", s_ra, 2'd3);
    cycle(0, 1, 4'hF, 4'h0); check("dual_drain2", s_ra, 2'd0);

    phase = "age_order";
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 4'h0, 4'h0);
    cycle(0, 0, 4'h0, 4'b0011);
    cycle(1, 0, 4'h0, 4'h0);
    cycle(1, 0, 4'h0, 4'h0);
    cycle(0, 1, 4'hF, 4'h0); check("ord0", s_ra, 2'd2);
    cycle(0, 1, 4'hF, 4'h0); check("ord1", s_ra, 2'd3);
    cycle(0, 1, 4'hF, 4'h0); check("ord2", s_ra, 2'd0);
    cycle(0, 1, 4'hF, 4'h0); check("ord3", s_ra, 2'd1);
    cycle(0, 1, 4'hF, 4'h0); check("ord_empty", s_iv, 1'b0);

    phase = "rst_hold";
    cycle(1, 0, 4'h0, 4'h0);
    cycle(1, 0, 4'h0, 4'h0);
    cycle(0, 0, 4'b0010, 4'h0);
    check("rh_raddr", s_ra, 2'd1);
    do_reset();
    cycle(1, 0, 4'h0, 4'h0);
    cycle(0, 0, 4'b0001, 4'h0);
    check("rh_after_issue_valid", s_iv, 1'b1);
    check("rh_after_raddr", s_ra, 2'd0);
    cycle(0, 1, 4'b0001, 4'h0);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            4'($urandom | $urandom),
            ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
